// File: rtl/kbd_queue.sv
// Keyboard event FIFO with a registered CPU read word and a non-empty interrupt.
// Optional feature: define KBD_QUEUE_DROP_COUNT_EN to report a saturating dropped-event count in bits [29:24].
package kbd_queue_pkg;
    localparam int unsigned EVENT_W = 10;
    typedef logic [EVENT_W-1:0] kbd_event_t;
endpackage

module kbd_queue
    import kbd_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  kbd_event_t  event_i,
    input  logic        valid_i,
    input  logic        pop_i,
    input  logic        clear_i,
    output logic [31:0] read_data_o,
    output logic        irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    kbd_event_t    mem [DEPTH];

    logic [PW-1:0] wr_q, rd_q;
    logic [PW-1:0] wr_d, rd_d;
    logic [PW-1:0] count_d;
    logic          ovf_q, ovf_d;
    logic          empty, full;
    logic          do_push, do_pop, drop;
    logic          ne_d;
    kbd_event_t    head_d;
    logic [5:0]    drop_field;
    logic [31:0]   word_d;

    // Next pointer/flag state; the pop is evaluated before the push so a full queue can accept both.
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});
        do_pop  = pop_i && !empty;
        do_push = valid_i && (!full || do_pop) && !clear_i;
        drop    = valid_i && full && !do_pop && !clear_i;
        wr_d    = wr_q + PW'(do_push);
        rd_d    = rd_q + PW'(do_pop);
        ovf_d   = ovf_q || drop;
        if (clear_i) begin
            wr_d  = '0;
            rd_d  = '0;
            ovf_d = 1'b0;
        end
    end

    // Head of the post-update queue; bypass the write when the new entry lands at the head slot.
    always_comb begin
        count_d = wr_d - rd_d;
        ne_d    = (wr_d != rd_d);
        head_d  = '0;
        if (ne_d) begin
            if (do_push && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
                head_d = event_i;
            end else begin
                head_d = mem[rd_d[AW-1:0]];
            end
        end
    end

`ifdef KBD_QUEUE_DROP_COUNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        drop_field = (|drop_cnt_d[7:6]) ? 6'h3F : drop_cnt_d[5:0];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`else
    always_comb begin
        drop_field = 6'd0;
    end
`endif

    always_comb begin
        word_d = {ne_d, ovf_d, drop_field, 8'(count_d), 6'd0, head_d};
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_q[AW-1:0]] <= event_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_q        <= '0;
            rd_q        <= '0;
            ovf_q       <= 1'b0;
            read_data_o <= 32'h0;
            irq_o       <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            ovf_q       <= ovf_d;
            read_data_o <= word_d;
            irq_o       <= ne_d;
        end
    end

endmodule

// File: tb/tb_kbd_queue.sv
// Self-checking bench for kbd_queue: constant vector table, directed corner sequences, random traffic against a queue model.
module tb_kbd_queue;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  event_in = '0;
    logic        valid = 1'b0;
    logic        pop = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] read_data;
    logic        irq;

    kbd_queue #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .event_i     (event_in),
        .valid_i     (valid),
        .pop_i       (pop),
        .clear_i     (clear),
        .read_data_o (read_data),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [9:0]  ev;
        logic        p;
        logic        c;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [10];
    logic [9:0]  mq [$];
    logic        m_ovf;
    int          m_drops;
    logic [31:0] exp_q [$];
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] model_word();
        logic [5:0] df;
        logic [9:0] hd;
`ifdef KBD_QUEUE_DROP_COUNT_EN
        df = (m_drops > 63) ? 6'h3F : 6'(m_drops);
`else
        df = 6'd0;
`endif
        hd = (mq.size() > 0) ? mq[0] : 10'd0;
        return {(mq.size() > 0), m_ovf, df, 8'(mq.size()), 6'd0, hd};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_apply(input logic v, input logic [9:0] ev, input logic p, input logic c);
        if (c) begin
            model_clear();
        end else begin
            if (p && mq.size() > 0) void'(mq.pop_front());
            if (v) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(ev);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, model updates at the edge, DUT sampled 1 time unit later.
    task automatic step(input logic v, input logic [9:0] ev, input logic p, input logic c);
        logic [31:0] e;
        @(negedge clk);
        valid    = v;
        event_in = ev;
        pop      = p;
        clear    = c;
        @(posedge clk);
        model_apply(v, ev, p, c);
        exp_q.push_back(model_word());
        #1;
        e = exp_q.pop_front();
        check32("read_data", read_data, e);
        check32("irq", 32'(irq), 32'(e[31]));
    endtask

    task automatic idle();
        step(1'b0, 10'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [9:0] first_ev;
        logic [9:0] new_ev;

        vecs[0] = '{1'b1, 10'h01C, 1'b0, 1'b0, 32'h8001001C};
        vecs[1] = '{1'b1, 10'h11C, 1'b0, 1'b0, 32'h8002001C};
        vecs[2] = '{1'b1, 10'h032, 1'b0, 1'b0, 32'h8003001C};
        vecs[3] = '{1'b0, 10'h000, 1'b0, 1'b0, 32'h8003001C};
        vecs[4] = '{1'b0, 10'h000, 1'b1, 1'b0, 32'h8002011C};
        vecs[5] = '{1'b0, 10'h000, 1'b0, 1'b0, 32'h8002011C};
        vecs[6] = '{1'b0, 10'h000, 1'b1, 1'b0, 32'h80010032};
        vecs[7] = '{1'b0, 10'h000, 1'b0, 1'b0, 32'h80010032};
        vecs[8] = '{1'b0, 10'h000, 1'b1, 1'b0, 32'h00000000};
        vecs[9] = '{1'b0, 10'h000, 1'b1, 1'b0, 32'h00000000};

        model_clear();
        #12;
        check32("reset_data", read_data, 32'h0);
        check32("reset_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Three pushes then three spaced pops, plus a pop while empty.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].v, vecs[i].ev, vecs[i].p, vecs[i].c);
            check32($sformatf("vec%0d", i), read_data, vecs[i].exp);
        end

        // Overfill by two.
        first_ev = 10'h2A5;
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, first_ev + 10'(i), 1'b0, 1'b0);
        check32("ovf_count", 32'(read_data[23:16]), DEPTH);
        check32("ovf_bit", 32'(read_data[30]), 32'd1);
        check32("ovf_head", 32'(read_data[9:0]), 32'(first_ev));
`ifdef KBD_QUEUE_DROP_COUNT_EN
        check32("ovf_drops", 32'(read_data[29:24]), 32'd2);
`else
        check32("ovf_drops_off", 32'(read_data[29:24]), 32'd0);
`endif

        // Full queue with coincident push and pop.
        step(1'b0, 10'd0, 1'b0, 1'b1);
        check32("clear_word", read_data, 32'h0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 10'(i + 1), 1'b0, 1'b0);
        new_ev = 10'h3C3;
        step(1'b1, new_ev, 1'b1, 1'b0);
        check32("full_pp_count", 32'(read_data[23:16]), DEPTH);
        check32("full_pp_ovf", 32'(read_data[30]), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 10'd0, 1'b1, 1'b0);
        check32("full_pp_head", 32'(read_data[9:0]), 32'(new_ev));
        check32("full_pp_last", 32'(read_data[23:16]), 32'd1);

        // Half-full clear racing a push.
        step(1'b0, 10'd0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, 10'(i + 100), 1'b0, 1'b0);
        step(1'b1, 10'h155, 1'b0, 1'b1);
        check32("clr_push_word", read_data, 32'h0);
        step(1'b1, 10'h0AA, 1'b0, 1'b0);
        check32("after_clr_push", read_data, 32'h800100AA);

        // Empty queue with coincident push and pop.
        step(1'b0, 10'd0, 1'b1, 1'b0);
        step(1'b1, 10'h077, 1'b1, 1'b0);
        check32("empty_pp", read_data, 32'h80010077);

        // Asynchronous reset between edges.
        step(1'b1, 10'h011, 1'b0, 1'b0);
        step(1'b1, 10'h022, 1'b0, 1'b0);
        valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check32("async_rst_data", read_data, 32'h0);
        check32("async_rst_irq", 32'(irq), 32'd0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 10'h1E1, 1'b0, 1'b0);
        check32("post_rst_push", read_data, 32'h800101E1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 1) == 1), 10'($urandom_range(0, 1023)),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
